unary_bsg_array: RTL and testbench

- Bitstream-generation stage directly downstream of the shared Sobol RNG array.
- Latches one vector of binary operands per job through a valid/ready handshake.
- Drives the RNG array's enable, then compares each operand against its lane's shared RNG word every cycle for a programmed stream length, emitting one unary bit per lane per cycle.
- Feeds the uBrain unary compute lanes.

---
 rtl/unary_bsg_array_pkg.sv | 15 +
 rtl/unary_bsg_array_if.sv | 26 ++
 rtl/unary_bsg_array_lane_cmp.sv | 26 ++
 rtl/unary_bsg_array.sv | 88 ++++++++
 tb/tb_unary_bsg_array.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/unary_bsg_array_pkg.sv
// rtl/unary_bsg_array_pkg.sv - shared state type and width helpers for the unary bitstream generator
package ubrain_bsg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } bsg_state_e;

    // One extra bit so a length code of 0 can count the full 2^RWID cycles.
    function automatic int cnt_width(input int rwid);
        return rwid + 1;
    endfunction

endpackage

// File: rtl/unary_bsg_array_if.sv
// rtl/unary_bsg_array_if.sv - job handshake, RNG link and bitstream outputs of the generator
interface unary_bsg_array_if #(
    parameter int RWID = 10,
    parameter int NUM  = 64
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM-1:0][RWID-1:0] in_data;
    logic [RWID-1:0]          in_len;
    logic                     abort;
    logic                     rng_en;
    logic [NUM-1:0][RWID-1:0] rng_seq;
    logic [NUM-1:0]           bit_out;
    logic                     bit_valid;
    logic                     done;

    modport master (
        output in_valid, in_data, in_len, abort, rng_seq,
        input  in_ready, rng_en, bit_out, bit_valid, done
    );

    modport slave (
        input  in_valid, in_data, in_len, abort, rng_seq,
        output in_ready, rng_en, bit_out, bit_valid, done
    );
endinterface

// File: rtl/unary_bsg_array_lane_cmp.sv
// rtl/unary_bsg_array_lane_cmp.sv - per-lane registered unsigned comparator (operand > rng)
module bsg_lane_cmp #(
    parameter int RWID = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_en,
    input  logic            i_clr,
    input  logic [RWID-1:0] i_opnd,
    input  logic [RWID-1:0] i_rng,
    output logic            o_bit
);
    logic r_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit <= 1'b0;
        end else if (i_clr) begin
            r_bit <= 1'b0;
        end else if (i_en) begin
            r_bit <= (i_opnd > i_rng);
        end
    end

    assign o_bit = r_bit;
endmodule

// File: rtl/unary_bsg_array.sv
// rtl/unary_bsg_array.sv - latches an operand vector per job and streams unary bits against the shared RNG
module unary_bsg_array
    import ubrain_bsg_pkg::*;
#(
    parameter int RWID = 10,
    parameter int BDIM = 2,
    parameter int TDIM = (BDIM < 1) ? 1 : BDIM,
    parameter int SDIM = 32
) (
    input logic              clk,
    input logic              rst,
    unary_bsg_array_if.slave bus
);
    localparam int NUM = TDIM * SDIM;
    localparam int CW  = cnt_width(RWID);

    bsg_state_e               r_state;
    logic [NUM-1:0][RWID-1:0] r_opnd;
    logic [RWID-1:0]          r_len;
    logic [CW-1:0]            r_cnt;
    logic                     r_bit_valid;
    logic                     r_done;

    logic                     w_accept;
    logic                     w_run;
    logic                     w_last;
    logic                     w_emit;
    logic [CW-1:0]            w_last_cnt;
    logic [NUM-1:0]           w_bits;

    assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
    assign w_run      = (r_state == ST_RUN);
    assign w_last_cnt = (r_len == '0) ? {1'b0, {RWID{1'b1}}} : ({1'b0, r_len} - CW'(1));
    assign w_last     = w_run && (r_cnt == w_last_cnt);
    // The final compare wins over a concurrent abort.
    assign w_emit     = w_run && (w_last || !bus.abort);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_opnd      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_bit_valid <= w_emit;
            r_done      <= w_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opnd  <= bus.in_data;
                        r_len   <= bus.in_len;
                        r_cnt   <= '0;
                        r_state <= ST_PRIME;
                    end
                end
                ST_PRIME: r_state <= bus.abort ? ST_IDLE : ST_RUN;
                ST_RUN: begin
                    if (w_last || bus.abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM; g++) begin : g_lane
        bsg_lane_cmp #(.RWID(RWID)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_run),
            .i_clr  (!w_emit),
            .i_opnd (r_opnd[g]),
            .i_rng  (bus.rng_seq[g]),
            .o_bit  (w_bits[g])
        );
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.rng_en    = (r_state != ST_IDLE);
    assign bus.bit_out   = w_bits;
    assign bus.bit_valid = r_bit_valid;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_unary_bsg_array.sv
// tb/tb_unary_bsg_array.sv - randomized self-checking bench for unary_bsg_array
module tb_unary_bsg_array;
    localparam int RWID = 10;
    localparam int NUM  = 64;

    typedef logic [NUM-1:0][RWID-1:0] vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   ones0;
    int   ones1;
    vec_t nxt_opnd;
    logic [RWID-1:0] nxt_len;

    unary_bsg_array_if #(.RWID(RWID), .NUM(NUM)) bus ();

    unary_bsg_array #(.RWID(RWID), .BDIM(2), .SDIM(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < NUM; k++) v[k] = RWID'($urandom_range(0, (1 << RWID) - 1));
        return v;
    endfunction

    function automatic vec_t ramp_vec(input int i);
        vec_t v;
        for (int k = 0; k < NUM; k++) v[k] = RWID'(i);
        return v;
    endfunction

    function automatic logic [NUM-1:0] exp_bits(input vec_t opnd, input vec_t rng);
        logic [NUM-1:0] e;
        for (int k = 0; k < NUM; k++) e[k] = (int'(opnd[k]) > int'(rng[k]));
        return e;
    endfunction

    // Called at a negedge with the DUT idle (or with the job already presented).
    task automatic run_job(input vec_t opnd, input logic [RWID-1:0] len_code, input int abort_at,
                           input bit presented, input bit chain, input bit hold, input bit ramp);
        int   len;
        int   k;
        bit   aborted;
        vec_t r;
        vec_t rng_q[$];
        len     = (len_code == '0) ? (1 << RWID) : int'(len_code);
        aborted = (abort_at >= 0) && (abort_at < len - 1);
        ones0   = 0;
        ones1   = 0;
        if (!presented) begin
            bus.in_valid = 1'b1;
            bus.in_data  = opnd;
            bus.in_len   = len_code;
        end
        @(negedge clk);
        chk("prime_ready", bus.in_ready, 0);
        chk("prime_rng_en", bus.rng_en, 1);
        chk("prime_bv", bus.bit_valid, 0);
        bus.in_valid = hold;
        bus.in_data  = rand_vec();
        bus.in_len   = RWID'($urandom);
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                k = c - 2;
                if (aborted && k >= abort_at) begin
                    chk("abort_bv", bus.bit_valid, 0);
                    chk("abort_done", bus.done, 0);
                    chk("abort_ready", bus.in_ready, 1);
                    chk("abort_rng_en", bus.rng_en, 0);
                    bus.abort    = 1'b0;
                    bus.in_valid = 1'b0;
                    return;
                end
                chk("bv", bus.bit_valid, 1);
                chk("bits", bus.bit_out, exp_bits(opnd, rng_q[k]));
                chk("done", bus.done, (k == len - 1));
                chk("ready", bus.in_ready, (c == len + 1));
                chk("rng_en", bus.rng_en, (c <= len));
                ones0 += int'(bus.bit_out[0]);
                ones1 += int'(bus.bit_out[1]);
            end else begin
                chk("run0_bv", bus.bit_valid, 0);
            end
            if (c <= len) begin
                r = ramp ? ramp_vec(c - 1) : rand_vec();
                rng_q.push_back(r);
                bus.rng_seq = r;
                bus.abort   = (c - 1 == abort_at);
                if (hold) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = rand_vec();
                end
            end else begin
                bus.abort = 1'b0;
                if (chain) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = nxt_opnd;
                    bus.in_len   = nxt_len;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        if (!chain) begin
            @(negedge clk);
            chk("idle_bv", bus.bit_valid, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_ready", bus.in_ready, 1);
        end
    endtask

    initial begin
        vec_t op;
        int   seen_done;
        int   len;
        int   ab;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_len   = '0;
        bus.abort    = 1'b0;
        bus.rng_seq  = rand_vec();
        #2;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_rng_en", bus.rng_en, 0);
        chk("rst_bits", bus.bit_out, 0);
        chk("rst_bv", bus.bit_valid, 0);
        chk("rst_done", bus.done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic job on a 0..7 ramp.
        for (int k = 0; k < NUM; k++) op[k] = RWID'(1023);
        op[0] = RWID'(512);
        op[1] = RWID'(0);
        run_job(op, RWID'(8), -1, 0, 0, 0, 1);
        chk("basic_ones0", ones0, 8);
        chk("basic_ones1", ones1, 0);

        // Abort in idle is ignored.
        bus.abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ready", bus.in_ready, 1);
        chk("idle_abort_rng_en", bus.rng_en, 0);
        bus.abort = 1'b0;

        // Full 2^RWID length on a full ramp.
        op = rand_vec();
        op[0] = RWID'(300);
        op[1] = RWID'(1023);
        run_job(op, RWID'(0), -1, 0, 0, 0, 1);
        chk("full_ones0", ones0, 300);
        chk("full_ones1", ones1, 1023);

        // Back-to-back jobs accepted on the done cycle.
        nxt_opnd = rand_vec();
        nxt_len  = RWID'(5);
        run_job(rand_vec(), RWID'(6), -1, 0, 1, 0, 0);
        run_job(nxt_opnd, RWID'(5), -1, 1, 0, 0, 0);

        // Abort mid-run and on the final compare.
        run_job(rand_vec(), RWID'(16), 4, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_abort_done", bus.done, 0);
        run_job(rand_vec(), RWID'(16), 15, 0, 0, 0, 0);

        // in_valid held through RUN with changing data.
        nxt_opnd = rand_vec();
        nxt_len  = RWID'(7);
        run_job(rand_vec(), RWID'(10), -1, 0, 1, 1, 0);
        run_job(nxt_opnd, RWID'(7), -1, 1, 0, 0, 0);

        // Randomized jobs, some aborted; length 1 boundary included.
        run_job(rand_vec(), RWID'(1), -1, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            len = $urandom_range(1, 24);
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            run_job(rand_vec(), RWID'(len), ab, 0, 0, 0, 0);
        end

        // Reset during RUN compare cycle 5.
        bus.in_valid = 1'b1;
        bus.in_data  = rand_vec();
        bus.in_len   = RWID'(20);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_bv", bus.bit_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bv", bus.bit_valid, 0);
        chk("arst_bits", bus.bit_out, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_rng_en", bus.rng_en, 0);
        chk("arst_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.in_ready, 1);
        seen_done = 0;
        repeat (25) begin
            @(negedge clk);
            seen_done += int'(bus.done) + int'(bus.bit_valid);
        end
        chk("post_rst_quiet", seen_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
